// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP test-pattern transmitter.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    VFP
  } state_t;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  // Index 0 is the leftmost bar; packed concatenation lists index 7 first.
  localparam logic [7:0][15:0] BAR_RGB = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

endpackage

// File: rtl/dvp_pattern_src.sv
// Combinational RGB565 pixel generator for the selected test pattern.
module dvp_pattern_src
  import dvp_pkg::*;
#(
  parameter int CHECK_LOG2 = 5
) (
  input  mode_t       mode,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [2:0]  bar,
  input  logic [4:0]  frame_count,
  input  logic [15:0] solid,
  output logic [15:0] pixel
);

  // Only some coordinate bits feed the patterns, depending on CHECK_LOG2.
  logic unused_bits;
  assign unused_bits = ^{x, y};

  always_comb begin
    pixel = '0;
    case (mode)
      MODE_BARS:  pixel = BAR_RGB[bar];
      MODE_GRAD:  pixel = {x[7:3], y[7:2], frame_count};
      MODE_CHECK: pixel = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
      default:    pixel = solid;
    endcase
  end

endmodule

// File: rtl/dvp_pattern_tx.sv
// OV7670-style DVP transmitter: frame timing FSM, slot/line/bar counters and
// registered camera outputs, with cam_pclk = clk/2.
module dvp_pattern_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10,
  parameter int CHECK_LOG2  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_rgb,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
  localparam int SLOT_W     = $clog2(LINE_SLOTS + 1);
  localparam int LINE_W     = $clog2(VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES + 1);
  localparam int BAR_W      = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BAR_CW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT    = SLOT_W'(LINE_SLOTS - 1);
  localparam logic [SLOT_W-1:0] ACT_SLOTS    = SLOT_W'(2 * H_ACTIVE);
  localparam logic [BAR_CW-1:0] LAST_BAR_PIX = BAR_CW'(BAR_W - 1);

  // Next frame segment, skipping any segment configured with zero lines.
  function automatic state_t seg_after(state_t s);
    state_t n;
    n = IDLE;
    case (s)
      IDLE:    n = (VSYNC_LINES != 0) ? VSYNC : (VBP_LINES != 0) ? VBP :
                   (V_ACTIVE != 0) ? ACTIVE : (VFP_LINES != 0) ? VFP : IDLE;
      VSYNC:   n = (VBP_LINES != 0) ? VBP : (V_ACTIVE != 0) ? ACTIVE :
                   (VFP_LINES != 0) ? VFP : IDLE;
      VBP:     n = (V_ACTIVE != 0) ? ACTIVE : (VFP_LINES != 0) ? VFP : IDLE;
      ACTIVE:  n = (VFP_LINES != 0) ? VFP : IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [LINE_W-1:0] last_line(state_t s);
    logic [LINE_W-1:0] l;
    l = '0;
    case (s)
      VSYNC:   l = LINE_W'(VSYNC_LINES - 1);
      VBP:     l = LINE_W'(VBP_LINES - 1);
      ACTIVE:  l = LINE_W'(V_ACTIVE - 1);
      VFP:     l = LINE_W'(VFP_LINES - 1);
      default: l = '0;
    endcase
    return l;
  endfunction

  logic              phase;
  state_t            state_q, state_n;
  logic [SLOT_W-1:0] slot_q, slot_n;
  logic [LINE_W-1:0] line_q, line_n;
  logic [2:0]        bar_idx_q, bar_idx_n;
  logic [BAR_CW-1:0] bar_cnt_q, bar_cnt_n;
  mode_t             mode_q, mode_sel;
  logic [15:0]       solid_q, solid_sel;
  logic [15:0]       fc_n;
  logic              start, frame_end, busy_n;
  logic              vsync_n, href_n;
  logic [7:0]        data_n;
  logic [15:0]       pixel;

  assign cam_pclk = phase;

  // Position of the slot to be emitted at the coming slot boundary.
  always_comb begin
    state_n   = state_q;
    slot_n    = slot_q;
    line_n    = line_q;
    bar_idx_n = bar_idx_q;
    bar_cnt_n = bar_cnt_q;
    start     = 1'b0;
    frame_end = 1'b0;
    if (state_q == IDLE) begin
      start = enable;
    end else if (slot_q != LAST_SLOT) begin
      slot_n = slot_q + 1'b1;
    end else begin
      slot_n = '0;
      if (line_q != last_line(state_q)) begin
        line_n = line_q + 1'b1;
      end else begin
        line_n  = '0;
        state_n = seg_after(state_q);
        if (state_n == IDLE) begin
          frame_end = 1'b1;
          start     = enable;
        end
      end
    end
    if (start) begin
      state_n = seg_after(IDLE);
      slot_n  = '0;
      line_n  = '0;
    end
    if (slot_n == '0) begin
      bar_idx_n = '0;
      bar_cnt_n = '0;
    end else if (!slot_n[0]) begin
      if (bar_cnt_q == LAST_BAR_PIX) begin
        bar_cnt_n = '0;
        bar_idx_n = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_n = bar_cnt_q + 1'b1;
      end
    end
    fc_n      = frame_end ? frame_count + 16'd1 : frame_count;
    busy_n    = start | (busy & ~frame_end);
    mode_sel  = start ? mode_t'(mode) : mode_q;
    solid_sel = start ? solid_rgb : solid_q;
  end

  dvp_pattern_src #(
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_src (
    .mode        (mode_sel),
    .x           (16'(slot_n >> 1)),
    .y           (16'(line_n)),
    .bar         (bar_idx_n),
    .frame_count (fc_n[4:0]),
    .solid       (solid_sel),
    .pixel       (pixel)
  );

  always_comb begin
    vsync_n = (state_n == VSYNC);
    href_n  = (state_n == ACTIVE) && (slot_n < ACT_SLOTS);
    data_n  = '0;
    if (href_n) data_n = slot_n[0] ? pixel[7:0] : pixel[15:8];
  end

  // Slot boundary: the edge where phase returns to 0, one clk before pclk rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= 1'b0;
      state_q     <= IDLE;
      slot_q      <= '0;
      line_q      <= '0;
      bar_idx_q   <= '0;
      bar_cnt_q   <= '0;
      mode_q      <= MODE_BARS;
      solid_q     <= '0;
      cam_vsync   <= 1'b0;
      cam_href    <= 1'b0;
      cam_data    <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      phase       <= ~phase;
      frame_start <= phase & start;
      if (phase) begin
        state_q     <= state_n;
        slot_q      <= slot_n;
        line_q      <= line_n;
        bar_idx_q   <= bar_idx_n;
        bar_cnt_q   <= bar_cnt_n;
        cam_vsync   <= vsync_n;
        cam_href    <= href_n;
        cam_data    <= data_n;
        frame_count <= fc_n;
        busy        <= busy_n;
        if (start) begin
          mode_q  <= mode_sel;
          solid_q <= solid_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Directed bench for dvp_pattern_tx with a small 8x4 frame geometry.
module tb_dvp_pattern_tx;

  localparam int FRAME_CLK = 280;
  localparam logic [127:0] BARS  = 128'hFFFF_FFE0_07FF_07E0_F81F_F800_001F_0000;
  localparam logic [127:0] CHK_A = 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF;
  localparam logic [127:0] CHK_B = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000;
  localparam logic [127:0] S1234 = 128'h1234_1234_1234_1234_1234_1234_1234_1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        cam_pclk, cam_vsync, cam_href, frame_start, busy;
  logic [7:0]  cam_data;
  logic [15:0] frame_count;

  dvp_pattern_tx #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4),
    .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1), .CHECK_LOG2(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .frame_start(frame_start), .frame_count(frame_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   mode;
    logic [15:0]  solid;
    logic [1:0]   y;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs [9];
  int           total = 0;
  int           passed = 0;
  bit           vs_a [FRAME_CLK];
  bit           hr_a [FRAME_CLK];
  bit           fs_a [FRAME_CLK];
  bit           busy_a [FRAME_CLK];
  bit           pclk_a [FRAME_CLK];
  logic [127:0] line_a [4];
  int           nbytes, zero_viol, stab_viol;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic wait_fs(input string name, input int max_clk);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_clk && !seen; k++) begin
      @(negedge clk);
      seen = frame_start;
    end
    check(name, 128'(seen), 128'd1);
  endtask

  // Records one frame starting at the frame_start sample; captures bytes the
  // way a receiver would (href high on the pclk-high half of each slot).
  task automatic run_frame(input int chg_at, input int drop_at);
    int   line;
    bit   prev_hr;
    logic [7:0] prev_d;
    line = -1; prev_hr = 1'b0; prev_d = '0;
    nbytes = 0; zero_viol = 0; stab_viol = 0;
    for (int l = 0; l < 4; l++) line_a[l] = '0;
    for (int i = 0; i < FRAME_CLK; i++) begin
      if (i > 0) @(negedge clk);
      if (i == chg_at) begin mode = 2'd0; solid_rgb = 16'h5555; end
      if (i == drop_at) enable = 1'b0;
      vs_a[i] = cam_vsync; hr_a[i] = cam_href; fs_a[i] = frame_start;
      busy_a[i] = busy; pclk_a[i] = cam_pclk;
      if (cam_href && !prev_hr) line++;
      if (cam_href && cam_pclk && line >= 0 && line < 4) begin
        line_a[line] = {line_a[line][119:0], cam_data};
        nbytes++;
      end
      if (!cam_href && cam_data != 8'h00) zero_viol++;
      if (i > 0 && cam_pclk && cam_data != prev_d) stab_viol++;
      prev_hr = cam_href;
      prev_d  = cam_data;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int vs_end, hr_first, hr_second, pulses, highs, fs_cnt, busy_low, toggles;
    int rises;
    bit prev;

    vecs[0] = '{mode: 2'd1, solid: 16'h0000, y: 2'd0, exp: 128'h0001_0001_0001_0001_0001_0001_0001_0001};
    vecs[1] = '{mode: 2'd0, solid: 16'h0000, y: 2'd0, exp: BARS};
    vecs[2] = '{mode: 2'd0, solid: 16'h0000, y: 2'd3, exp: BARS};
    vecs[3] = '{mode: 2'd2, solid: 16'h0000, y: 2'd0, exp: CHK_A};
    vecs[4] = '{mode: 2'd2, solid: 16'h0000, y: 2'd1, exp: CHK_A};
    vecs[5] = '{mode: 2'd2, solid: 16'h0000, y: 2'd2, exp: CHK_B};
    vecs[6] = '{mode: 2'd2, solid: 16'h0000, y: 2'd3, exp: CHK_B};
    vecs[7] = '{mode: 2'd3, solid: 16'h1234, y: 2'd1, exp: S1234};
    vecs[8] = '{mode: 2'd3, solid: 16'hF00D, y: 2'd2, exp: {8{16'hF00D}}};

    repeat (2) @(negedge clk);
    check("reset_ctrl", 128'({cam_pclk, cam_vsync, cam_href, cam_data, frame_start, busy}), 128'd0);
    check("reset_frame_count", 128'(frame_count), 128'd0);

    // Frame 0: timing.
    enable = 1'b1; mode = 2'd0; rst = 1'b0;
    wait_fs("fs_first", 6);
    run_frame(-1, -1);
    vs_end = -1; hr_first = -1; hr_second = -1; pulses = 0; highs = 0;
    fs_cnt = 0; busy_low = 0; toggles = 0;
    for (int i = 0; i < FRAME_CLK; i++) begin
      if (!vs_a[i] && vs_end < 0) vs_end = i;
      if (hr_a[i] && (i == 0 || !hr_a[(i > 0) ? i - 1 : 0])) begin
        pulses++;
        if (hr_first < 0) hr_first = i;
        else if (hr_second < 0) hr_second = i;
      end
      if (hr_a[i]) highs++;
      if (fs_a[i]) fs_cnt++;
      if (!busy_a[i]) busy_low++;
      if (i > 0 && pclk_a[i] != pclk_a[i-1]) toggles++;
    end
    check("pclk_at_fs", 128'(pclk_a[0]), 128'd0);
    check("vsync_at_fs", 128'(vs_a[0]), 128'd1);
    check("vsync_fall_clk", 128'(vs_end), 128'd40);
    check("href_first_rise", 128'(hr_first), 128'd80);
    check("href_line1_rise", 128'(hr_second), 128'd120);
    check("href_pulses", 128'(pulses), 128'd4);
    check("href_high_clks", 128'(highs), 128'd128);
    check("href_low_after_32", 128'({hr_a[111], hr_a[112]}), 128'b10);
    check("fs_count_frame0", 128'(fs_cnt), 128'd1);
    check("busy_low_frame0", 128'(busy_low), 128'd0);
    check("pclk_toggles", 128'(toggles), 128'd279);
    check("data_stable_before_pclk", 128'(stab_viol), 128'd0);
    check("bars_line0_frame0", line_a[0], BARS);

    // Frames 1..9: one table vector per frame, mode latched at each frame_start.
    for (int v = 0; v < 9; v++) begin
      mode = vecs[v].mode;
      solid_rgb = vecs[v].solid;
      wait_fs($sformatf("vec%0d_fs_on_time", v), 1);
      check($sformatf("vec%0d_frame_count", v), 128'(frame_count), 128'(v + 1));
      run_frame(-1, -1);
      check($sformatf("vec%0d_line", v), line_a[vecs[v].y], vecs[v].exp);
      check($sformatf("vec%0d_bytes", v), 128'(nbytes), 128'd64);
      check($sformatf("vec%0d_data_zero_blank", v), 128'(zero_viol), 128'd0);
    end

    // Frame 10: mode and solid change mid-frame are ignored.
    mode = 2'd3; solid_rgb = 16'h1234;
    wait_fs("fs_frame10", 1);
    check("fc_frame10", 128'(frame_count), 128'd10);
    run_frame(100, -1);
    check("solid_kept_line0", line_a[0], S1234);
    check("solid_kept_line3", line_a[3], S1234);

    // Frame 11: new mode takes effect; enable drops mid-frame.
    wait_fs("fs_frame11", 1);
    run_frame(-1, 100);
    check("bars_after_switch_line0", line_a[0], BARS);
    check("bars_after_switch_line3", line_a[3], BARS);
    check("busy_during_last_frame", 128'(busy_low), 128'd0);
    @(negedge clk);
    check("end_busy_fs", 128'({busy, frame_start}), 128'd0);
    check("end_frame_count", 128'(frame_count), 128'd12);
    fs_cnt = 0; highs = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (frame_start) fs_cnt++;
      if (busy || cam_vsync || cam_href) highs++;
    end
    check("idle_no_frame_start", 128'(fs_cnt), 128'd0);
    check("idle_quiet", 128'(highs), 128'd0);

    // Reset on the third active line.
    enable = 1'b1;
    wait_fs("fs_reenable", 4);
    check("fc_reenable", 128'(frame_count), 128'd12);
    rises = 0; prev = cam_href;
    for (int i = 0; i < 300 && rises < 3; i++) begin
      @(negedge clk);
      if (cam_href && !prev) rises++;
      prev = cam_href;
    end
    check("third_href_seen", 128'(rises), 128'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midframe_reset_ctrl", 128'({cam_pclk, cam_vsync, cam_href, cam_data, frame_start, busy}), 128'd0);
    check("midframe_reset_fc", 128'(frame_count), 128'd0);
    wait_fs("fs_after_reset", 4);
    check("fc_after_reset", 128'(frame_count), 128'd0);
    run_frame(-1, -1);
    check("bars_after_reset_line2", line_a[2], BARS);
    wait_fs("fs_after_reset_frame", 1);
    check("fc_after_reset_frame", 128'(frame_count), 128'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
